esdi_rotation_timer: RTL
========================

# esdi_rotation_timer

Parametrised disk-rotation timing generator for the ESDI drive emulator. It models a spinning platter from the system clock and produces the drive-side INDEX and SECTOR pulses, a byte-cell strobe and the current angular position (byte and sector number) used by the read/write data paths. It replaces the fixed index/sector sources and the external drive-selected gating. It adds runtime-configurable sector geometry, a hard/soft-sector mode, and configuration changes applied only at index.

## Interface
Parameters:
- CLK_PER_BYTE, 100: system clocks per emulated byte cell (125 MHz / 1.25 MB/s); must be ≥ 2.
- BYTES_PER_TRACK, 20833: byte cells per revolution; position wraps here.
- MAX_SECTORS, 64: largest allowed sectors_per_track.
- INDEX_WIDTH, 125: INDEX pulse width in clocks, ≥ 1.
- SECTOR_WIDTH, 125: SECTOR pulse width in clocks, ≥ 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  spindle running; low stops and clears the rotation.
- hard_sector  in  1  1 = SECTOR pulses generated; 0 = soft-sectored, SECTOR held low.
- sectors_per_track  in  clog2(MAX_SECTORS+1)  requested sectors per track.
- bytes_per_sector  in  16  requested byte cells per sector, including gaps.
- cfg_load  in  1  one-clock strobe capturing the three config inputs into a pending register.
- drive_selected  in  1  gates index/sector outputs.
- index  out  1  INDEX pulse, gated by drive_selected.
- sector  out  1  SECTOR pulse, gated by drive_selected.
- byte_strobe  out  1  one-clock pulse per byte cell.
- byte_pos  out  clog2(BYTES_PER_TRACK)  current byte cell, 0..BYTES_PER_TRACK-1.
- sector_num  out  clog2(MAX_SECTORS+1)  current sector; equals active sectors_per_track in the trailing gap.

## Operation
- States: IDLE, SPIN. Reset → IDLE. In IDLE: prescaler, byte_pos, sector_num, in-sector byte counter and pulse counters are 0; raw pulses are low.
- IDLE→SPIN on a clock where enable=1. On that edge: byte_pos=0, sector_num=0, and the INDEX pulse starts. The SECTOR pulse also starts if active hard_sector=1 and sectors_per_track≠0.
- SPIN→IDLE on any clock where enable=0. All counters clear on that edge, and outputs are low from the next cycle.
- Prescaler counts 0..CLK_PER_BYTE-1. On the terminal count it raises byte_strobe for one clock and advances the position.
- Position advance: byte_pos increments.
  - At BYTES_PER_TRACK-1 it wraps to 0 (index event): sector_num=0, in-sector counter=0, pending config copies to active config, INDEX starts, and SECTOR starts if enabled by the new active config.
  - Otherwise the in-sector counter increments. When it reaches active bytes_per_sector-1, it clears and sector_num increments, saturating at active sectors_per_track. If the new sector_num < sectors_per_track, a SECTOR pulse starts.
  - After the last sector, no SECTOR pulses until the next index (trailing gap).
- Index event has priority over a coincident sector boundary.
- Degenerate config: sectors_per_track=0, or bytes_per_sector=0 or 1, gives no sector pulses other than the one at index when sectors_per_track≠0. Values > MAX_SECTORS are clamped to MAX_SECTORS on load.
- Pulse generation: a start loads a down-counter with the width, and the raw pulse is high while the counter is non-zero. A start while the pulse is already active reloads the counter (retrigger, no gap).
- Outputs: index = raw_index AND drive_selected; sector = raw_sector AND drive_selected. This gating is combinational.
- byte_pos, sector_num and byte_strobe run regardless of drive_selected.
- cfg_load in IDLE also copies straight to the active config. A second cfg_load before index overwrites the pending value.

## Timing
- Reset values: index=0, sector=0, byte_strobe=0, byte_pos=0, sector_num=0. Active config resets to sectors_per_track=MAX_SECTORS, bytes_per_sector=BYTES_PER_TRACK/MAX_SECTORS, hard_sector=1.
- Reset is asynchronous, so mid-revolution assertion clears everything immediately. Rotation restarts from byte 0 on the first enabled clock after release.
- The first INDEX is high in the cycle following the enabling edge, for exactly INDEX_WIDTH clocks.
- Index period is exactly CLK_PER_BYTE×BYTES_PER_TRACK clocks.
- Sector k's pulse rises CLK_PER_BYTE×bytes_per_sector×k clocks after INDEX rises.
- byte_pos and sector_num update on the same edge that asserts byte_strobe.
- Config change latency: effective from the first index event after cfg_load, never mid-revolution.

## Test plan
Use CLK_PER_BYTE=4, BYTES_PER_TRACK=40, MAX_SECTORS=8, INDEX_WIDTH=3, SECTOR_WIDTH=2.
- Load spt=4, bps=10, hard, drive_selected=1, enable → INDEX high 3 clocks every 160 clocks. SECTOR rises at clocks 0/40/80/120 relative to INDEX, 2 clocks wide. sector_num steps 0..3.
- Load spt=3, bps=10 → SECTOR only at bytes 0/10/20; sector_num=3 for bytes 30–39; INDEX period unchanged at 160.
- Load hard_sector=0 while spinning → SECTOR continues until the next index, then stays 0. INDEX is unaffected.
- Drop drive_selected mid-pulse → index/sector low the same cycle; byte_pos keeps counting. Restore → the remainder of an active pulse reappears.
- Assert reset at byte_pos=17 → all outputs 0 asynchronously. After release with enable=1 → INDEX high on the next cycle, byte_pos=0.
- Load spt=20 → clamped to 8. Load bps=0 → only the index-coincident SECTOR pulse per revolution.

Source files
------------

// File: rtl/esdi_rotation_timer.sv
`default_nettype none
// ============================================================================
// Module   : esdi_rotation_timer
// Purpose  : Disk-rotation timing generator for the ESDI drive emulator.
//            Models a spinning platter from the system clock and produces the
//            drive-side INDEX and SECTOR pulses, a byte-cell strobe and the
//            current angular position (byte cell and sector number).
//            Sector geometry and hard/soft-sector mode are runtime
//            configurable; a loaded configuration becomes active at the next
//            index event (or immediately while the spindle is stopped).
// Ports    :
//   clk_i               system clock, all state on the rising edge
//   rst_ni              asynchronous active-low reset
//   enable_i            spindle running; low stops and clears the rotation
//   hard_sector_i       1 = SECTOR pulses generated, 0 = SECTOR held low
//   sectors_per_track_i requested sectors per track (clamped to MAX_SECTORS)
//   bytes_per_sector_i  requested byte cells per sector, including gaps
//   cfg_load_i          one-clock strobe capturing the three config inputs
//   drive_selected_i    gates index_o / sector_o
//   index_o             INDEX pulse, gated by drive_selected_i
//   sector_o            SECTOR pulse, gated by drive_selected_i
//   byte_strobe_o       one-clock pulse per byte cell
//   byte_pos_o          current byte cell, 0..BYTES_PER_TRACK-1
//   sector_num_o        current sector (equals sectors/track in trailing gap)
// Revision : 1.0 - initial release
// ============================================================================
module esdi_rotation_timer #(
  parameter int CLK_PER_BYTE    = 100,
  parameter int BYTES_PER_TRACK = 20833,
  parameter int MAX_SECTORS     = 64,
  parameter int INDEX_WIDTH     = 125,
  parameter int SECTOR_WIDTH    = 125
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               enable_i,
  input  logic                               hard_sector_i,
  input  logic [$clog2(MAX_SECTORS+1)-1:0]   sectors_per_track_i,
  input  logic [15:0]                        bytes_per_sector_i,
  input  logic                               cfg_load_i,
  input  logic                               drive_selected_i,
  output logic                               index_o,
  output logic                               sector_o,
  output logic                               byte_strobe_o,
  output logic [$clog2(BYTES_PER_TRACK)-1:0] byte_pos_o,
  output logic [$clog2(MAX_SECTORS+1)-1:0]   sector_num_o
);

  localparam int SPT_W = $clog2(MAX_SECTORS + 1);
  localparam int POS_W = $clog2(BYTES_PER_TRACK);
  localparam int PRE_W = $clog2(CLK_PER_BYTE);
  localparam int IW_W  = $clog2(INDEX_WIDTH + 1);
  localparam int SW_W  = $clog2(SECTOR_WIDTH + 1);
  localparam int BPS_W = 16;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_BYTE - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(BYTES_PER_TRACK - 1);
  localparam logic [SPT_W-1:0] SPT_MAX  = SPT_W'(MAX_SECTORS);
  localparam logic [BPS_W-1:0] BPS_RST  = BPS_W'(BYTES_PER_TRACK / MAX_SECTORS);
  localparam logic [IW_W-1:0]  IDX_LOAD = IW_W'(INDEX_WIDTH);
  localparam logic [SW_W-1:0]  SEC_LOAD = SW_W'(SECTOR_WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SPIN = 1'b1
  } state_e;

  typedef struct packed {
    logic             hard;
    logic [SPT_W-1:0] spt;
    logic [BPS_W-1:0] bps;
  } cfg_t;

  localparam cfg_t CFG_RST = '{hard: 1'b1, spt: SPT_MAX, bps: BPS_RST};

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [SPT_W-1:0] snum_q, snum_d;
  logic [BPS_W-1:0] insec_q, insec_d;
  logic [IW_W-1:0]  idx_cnt_q, idx_cnt_d;
  logic [SW_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic             strobe_q, strobe_d;
  cfg_t             pend_q, pend_d;
  cfg_t             act_q, act_d;

  cfg_t             cfg_in;
  logic [SPT_W-1:0] snum_inc;
  logic             sec_boundary;

  // Captured configuration; out-of-range sector counts saturate.
  always_comb begin
    cfg_in.hard = hard_sector_i;
    cfg_in.spt  = (sectors_per_track_i > SPT_MAX) ? SPT_MAX : sectors_per_track_i;
    cfg_in.bps  = bytes_per_sector_i;
  end

  // Sector length of 0 or 1 byte is degenerate: no intra-track boundaries.
  assign sec_boundary = (act_q.bps >= BPS_W'(2)) &&
                        (insec_q == act_q.bps - BPS_W'(1));
  assign snum_inc     = snum_q + SPT_W'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      pos_q     <= '0;
      snum_q    <= '0;
      insec_q   <= '0;
      idx_cnt_q <= '0;
      sec_cnt_q <= '0;
      strobe_q  <= 1'b0;
      pend_q    <= CFG_RST;
      act_q     <= CFG_RST;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      pos_q     <= pos_d;
      snum_q    <= snum_d;
      insec_q   <= insec_d;
      idx_cnt_q <= idx_cnt_d;
      sec_cnt_q <= sec_cnt_d;
      strobe_q  <= strobe_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    pos_d     = pos_q;
    snum_d    = snum_q;
    insec_d   = insec_q;
    strobe_d  = 1'b0;
    pend_d    = pend_q;
    act_d     = act_q;
    // Pulse down-counters free-run towards zero unless (re)started below.
    idx_cnt_d = (idx_cnt_q != '0) ? idx_cnt_q - IW_W'(1) : '0;
    sec_cnt_d = (sec_cnt_q != '0) ? sec_cnt_q - SW_W'(1) : '0;

    if (cfg_load_i) begin
      pend_d = cfg_in;
    end

    case (state_q)
      ST_IDLE: begin
        // Stopped spindle: new configuration needs no index to take effect.
        if (cfg_load_i) begin
          act_d = cfg_in;
        end
        if (enable_i) begin
          state_d   = ST_SPIN;
          pre_d     = '0;
          pos_d     = '0;
          snum_d    = '0;
          insec_d   = '0;
          idx_cnt_d = IDX_LOAD;
          if (act_q.hard && (act_q.spt != '0)) begin
            sec_cnt_d = SEC_LOAD;
          end
        end
      end

      ST_SPIN: begin
        if (!enable_i) begin
          state_d   = ST_IDLE;
          pre_d     = '0;
          pos_d     = '0;
          snum_d    = '0;
          insec_d   = '0;
          idx_cnt_d = '0;
          sec_cnt_d = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d    = '0;
          strobe_d = 1'b1;
          if (pos_q == POS_LAST) begin
            // Index event: wins over any coincident sector boundary and is
            // the only point where the pending configuration goes live.
            pos_d     = '0;
            snum_d    = '0;
            insec_d   = '0;
            act_d     = pend_q;
            idx_cnt_d = IDX_LOAD;
            if (pend_q.hard && (pend_q.spt != '0)) begin
              sec_cnt_d = SEC_LOAD;
            end
          end else begin
            pos_d = pos_q + POS_W'(1);
            if (sec_boundary) begin
              insec_d = '0;
              // sector_num saturates at the sector count: trailing gap.
              if (snum_q < act_q.spt) begin
                snum_d = snum_inc;
                if (act_q.hard && (snum_inc < act_q.spt)) begin
                  sec_cnt_d = SEC_LOAD;
                end
              end
            end else begin
              insec_d = insec_q + BPS_W'(1);
            end
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: drive-select gating is combinational so a deselect blanks the
  // pulses in the same cycle and a reselect shows any remaining pulse.
  // --------------------------------------------------------------------------
  assign index_o       = (idx_cnt_q != '0) & drive_selected_i;
  assign sector_o      = (sec_cnt_q != '0) & drive_selected_i;
  assign byte_strobe_o = strobe_q;
  assign byte_pos_o    = pos_q;
  assign sector_num_o  = snum_q;

endmodule
`default_nettype wire
